// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: load-use, mul/div, memory-wait and branch stall/flush scheduler for ID
module pipe_stall_ctrl #(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 32
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [4:0]       rs_i,
  input  logic [4:0]       rt_i,
  input  logic             use_rs_i,
  input  logic             use_rt_i,
  input  logic [4:0]       ern_i,
  input  logic             ewreg_i,
  input  logic             em2reg_i,
  input  logic             md_req_i,
  input  logic             branch_i,
  input  logic             mem_wait_i,
  output logic             wpcir_o,
  output logic             id_bubble_o,
  output logic             if_flush_o,
  output logic             pipe_freeze_o,
  output logic             md_start_o,
  output logic             md_busy_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  typedef enum logic {RUN, MD_WAIT} state_e;
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             md_ack_q, md_ack_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             load_use, run, launch;
  assign load_use = ewreg_i & em2reg_i & (ern_i != 5'd0) &
                    ((use_rs_i & (ern_i == rs_i)) | (use_rt_i & (ern_i == rt_i)));
  assign run      = state_q == RUN;
  assign launch   = run & ~mem_wait_i & ~load_use & md_req_i & ~md_ack_q;
  assign md_busy_o   = state_q == MD_WAIT;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
  // state, latency counter and release flag; reset aborts any mul/div sequence
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      md_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      md_ack_q <= md_ack_d;
    end
  end
  // next state: launch from RUN, count down in MD_WAIT (paused by mem_wait), release with ack
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_ack_d = md_ack_q;
    if (run) begin
      if (launch) begin
        state_d = MD_WAIT;
        cnt_d   = CW'(MD_LAT - 1);
      end else if (~mem_wait_i & ~load_use) begin
        md_ack_d = 1'b0;
      end
    end else if (~mem_wait_i) begin
      state_d  = (cnt_q == '0) ? RUN : MD_WAIT;
      md_ack_d = (cnt_q == '0) ? 1'b1 : md_ack_q;
      cnt_d    = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
    end
  end
  // same-cycle pipeline controls; reset forces a free-running, flush-free pipeline
  always_comb begin
    wpcir_o       = reset_i | (run & ~mem_wait_i & ~load_use & ~launch);
    pipe_freeze_o = ~reset_i & mem_wait_i;
    md_start_o    = ~reset_i & launch;
    id_bubble_o   = ~reset_i & ~mem_wait_i & ~wpcir_o;
    if_flush_o    = ~reset_i & wpcir_o & branch_i;
  end
  // saturating statistics counters
  always_comb begin
    stall_cnt_d = (~wpcir_o & ~&stall_cnt_q) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (if_flush_o & ~&flush_cnt_q) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end
  // statistics registers
  always_ff @(posedge clock_i) begin
    stall_cnt_q <= reset_i ? '0 : stall_cnt_d;
    flush_cnt_q <= reset_i ? '0 : flush_cnt_d;
  end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed scenarios plus randomized run against a cycle-level reference model
module tb_pipe_stall_ctrl;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] rs = '0, rt = '0, ern = '0;
  logic use_rs = 0, use_rt = 0, ewreg = 0, em2reg = 0, md_req = 0, branch = 0, mem_wait = 0;
  logic wpcir, id_bubble, if_flush, pipe_freeze, md_start, md_busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clock_i(clk), .reset_i(reset), .rs_i(rs), .rt_i(rt), .use_rs_i(use_rs), .use_rt_i(use_rt),
    .ern_i(ern), .ewreg_i(ewreg), .em2reg_i(em2reg), .md_req_i(md_req), .branch_i(branch),
    .mem_wait_i(mem_wait), .wpcir_o(wpcir), .id_bubble_o(id_bubble), .if_flush_o(if_flush),
    .pipe_freeze_o(pipe_freeze), .md_start_o(md_start), .md_busy_o(md_busy),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  task automatic idle();
    rs = '0; rt = '0; ern = '0; use_rs = 0; use_rt = 0; ewreg = 0; em2reg = 0;
    md_req = 0; branch = 0; mem_wait = 0;
  endtask

  task automatic load_hazard(input logic [4:0] r);
    ewreg = 1; em2reg = 1; ern = r; rs = r; use_rs = 1;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    idle();
    adv();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    md_req = 1; mem_wait = 1; branch = 1;
    load_hazard(5'd7);
    @(negedge clk);
    checks++;
    if ({wpcir, id_bubble, if_flush, pipe_freeze, md_start} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_comb got=%b exp=10000", {wpcir, id_bubble, if_flush, pipe_freeze, md_start});
    end
    checks++;
    if ({md_busy, stall_cnt, flush_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_regs busy=%b stall=%0d flush=%0d exp all 0", md_busy, stall_cnt, flush_cnt);
    end
    adv();
    reset = 0;
    idle();
  endtask

  task automatic test_load_use();
    load_hazard(5'd5);
    @(negedge clk);
    checks++;
    if ({wpcir, id_bubble, if_flush} !== 3'b010) begin
      failures++;
      $display("FAIL load_use got=%b exp=010", {wpcir, id_bubble, if_flush});
    end
    adv();
    load_hazard(5'd0);
    @(negedge clk);
    checks++;
    if ({wpcir, id_bubble, stall_cnt} !== {2'b10, 4'd1}) begin
      failures++;
      $display("FAIL load_use_r0 wpcir=%b bubble=%b stall=%0d exp 1 0 1", wpcir, id_bubble, stall_cnt);
    end
    adv();
    load_hazard(5'd9);
    use_rs = 0; use_rt = 0; rt = 5'd9;
    @(negedge clk);
    checks++;
    if (wpcir !== 1'b1) begin
      failures++;
      $display("FAIL load_use_unused got=%b exp=1", wpcir);
    end
    adv();
    idle();
  endtask

  task automatic test_md();
    int starts = 0, stalls = 0, busy = 0;
    do_reset();
    md_req = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      starts += md_start;
      stalls += !wpcir;
      busy += md_busy;
      adv();
    end
    md_req = 0;
    @(negedge clk);
    checks++;
    if (starts != 1 || stalls != MD_LAT + 1 || busy != MD_LAT) begin
      failures++;
      $display("FAIL md_seq starts=%0d stalls=%0d busy=%0d exp 1 %0d %0d", starts, stalls, busy, MD_LAT + 1, MD_LAT);
    end
    checks++;
    if (stall_cnt !== 4'(MD_LAT + 1)) begin
      failures++;
      $display("FAIL md_stall_cnt got=%0d exp=%0d", stall_cnt, MD_LAT + 1);
    end
    adv();
  endtask

  task automatic test_md_mem_wait();
    int busy = 0, frz = 0, starts = 0;
    logic last_w;
    do_reset();
    md_req = 1;
    for (int c = 0; c < 9; c++) begin
      mem_wait = (c >= 2 && c <= 4);
      @(negedge clk);
      busy += md_busy;
      starts += md_start;
      if (mem_wait && pipe_freeze && !id_bubble && !wpcir) frz++;
      last_w = wpcir;
      adv();
    end
    md_req = 0; mem_wait = 0;
    checks++;
    if (busy != MD_LAT + 3 || frz != 3 || starts != 1) begin
      failures++;
      $display("FAIL md_mem_wait busy=%0d freeze=%0d starts=%0d exp %0d 3 1", busy, frz, starts, MD_LAT + 3);
    end
    checks++;
    if (last_w !== 1'b1) begin
      failures++;
      $display("FAIL md_mem_wait_release wpcir=%b exp=1", last_w);
    end
  endtask

  task automatic test_branch();
    do_reset();
    load_hazard(5'd3);
    branch = 1;
    @(negedge clk);
    checks++;
    if ({if_flush, id_bubble} !== 2'b01) begin
      failures++;
      $display("FAIL branch_lu flush=%b bubble=%b exp 0 1", if_flush, id_bubble);
    end
    adv();
    ewreg = 0;
    @(negedge clk);
    checks++;
    if ({if_flush, wpcir} !== 2'b11) begin
      failures++;
      $display("FAIL branch_flush flush=%b wpcir=%b exp 1 1", if_flush, wpcir);
    end
    adv();
    idle();
    @(negedge clk);
    checks++;
    if (flush_cnt !== 4'd1 || if_flush !== 1'b0) begin
      failures++;
      $display("FAIL flush_cnt got=%0d flush=%b exp 1 0", flush_cnt, if_flush);
    end
    adv();
  endtask

  task automatic test_md_branch();
    int flush_seen = 0;
    do_reset();
    md_req = 1; branch = 1;
    for (int c = 0; c < MD_LAT + 2; c++) begin
      @(negedge clk);
      if (if_flush) flush_seen = (c == MD_LAT + 1) ? flush_seen + 1 : flush_seen + 100;
      adv();
    end
    idle();
    checks++;
    if (flush_seen != 1) begin
      failures++;
      $display("FAIL md_branch flush_code=%0d exp=1", flush_seen);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    load_hazard(5'd12);
    repeat (20) adv();
    idle();
    @(negedge clk);
    checks++;
    if (stall_cnt !== 4'd15) begin
      failures++;
      $display("FAIL stall_sat got=%0d exp=15", stall_cnt);
    end
    adv();
  endtask

  task automatic test_reset_mid_md();
    do_reset();
    md_req = 1;
    adv();
    adv();
    reset = 1;
    @(negedge clk);
    checks++;
    if ({wpcir, md_start, id_bubble} !== 3'b100) begin
      failures++;
      $display("FAIL reset_mid_md_comb got=%b exp=100", {wpcir, md_start, id_bubble});
    end
    adv();
    reset = 0;
    @(negedge clk);
    checks++;
    if ({md_busy, md_start} !== 2'b01 || stall_cnt !== '0 || flush_cnt !== '0) begin
      failures++;
      $display("FAIL reset_mid_md busy=%b start=%b stall=%0d flush=%0d exp 0 1 0 0", md_busy, md_start, stall_cnt, flush_cnt);
    end
    adv();
    idle();
    do_reset();
  endtask

  task automatic test_random();
    int m_left = 0, m_stall = 0, m_flush = 0;
    bit m_done = 0, lu;
    bit [4:0] exp_o, got_o;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 39) == 0);
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); ern = 5'($urandom_range(0, 3));
      use_rs = 1'($urandom); use_rt = 1'($urandom);
      ewreg = 1'($urandom); em2reg = ($urandom_range(0, 2) == 0);
      md_req = ($urandom_range(0, 3) == 0); branch = ($urandom_range(0, 3) == 0);
      mem_wait = ($urandom_range(0, 4) == 0);
      lu = ewreg && em2reg && ern != 0 && ((use_rs && ern == rs) || (use_rt && ern == rt));
      if (reset) exp_o = 5'b10000;
      else if (m_left > 0) exp_o = mem_wait ? 5'b00010 : 5'b01000;
      else if (mem_wait) exp_o = 5'b00010;
      else if (lu) exp_o = 5'b01000;
      else if (md_req && !m_done) exp_o = 5'b01001;
      else exp_o = {2'b10, branch, 2'b00};
      @(negedge clk);
      got_o = {wpcir, id_bubble, if_flush, pipe_freeze, md_start};
      checks++;
      if (got_o !== exp_o || md_busy !== (m_left > 0) || stall_cnt !== 4'(m_stall) || flush_cnt !== 4'(m_flush)) begin
        failures++;
        $display("FAIL random c=%0d outs=%b/%b busy=%b/%b stall=%0d/%0d flush=%0d/%0d (got/exp)",
                 c, got_o, exp_o, md_busy, m_left > 0, stall_cnt, m_stall, flush_cnt, m_flush);
      end
      if (reset) begin
        m_left = 0; m_done = 0; m_stall = 0; m_flush = 0;
      end else begin
        if (!exp_o[4]) m_stall = (m_stall < 15) ? m_stall + 1 : 15;
        if (exp_o[2]) m_flush = (m_flush < 15) ? m_flush + 1 : 15;
        if (m_left > 0) begin
          if (!mem_wait) begin
            m_left--;
            if (m_left == 0) m_done = 1;
          end
        end else if (!mem_wait && !lu) begin
          if (md_req && !m_done) m_left = MD_LAT;
          else m_done = 0;
        end
      end
      adv();
    end
    reset = 0;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_md();
    test_md_mem_wait();
    test_branch();
    test_md_branch();
    test_saturation();
    test_reset_mid_md();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
